// File: rtl/pipo_reg.sv
// pipo_reg: parallel-in/parallel-out register with per-lane write mask, loaded flag and change strobe.
// Optional even-parity output and error injection when PIPO_PARITY_EN is defined.
module pipo_reg #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [LANES-1:0] lane_en,
  input  logic [WIDTH-1:0] pin,
`ifdef PIPO_PARITY_EN
  input  logic             par_err_inj,
  output logic             par,
`endif
  output logic [WIDTH-1:0] pout,
  output logic             loaded,
  output logic             chg
);
  localparam int LW = WIDTH / LANES;
  logic [WIDTH-1:0] r_pout;
  logic             r_loaded;
  logic             r_chg;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_next;
  logic             w_any;
  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign w_mask[i*LW +: LW] = {LW{lane_en[i]}};
  end
  assign w_any  = ld & |lane_en;
  assign w_next = ld ? (pin & w_mask) | (r_pout & ~w_mask) : r_pout;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pout   <= RESET_VALUE;
      r_loaded <= 1'b0;
      r_chg    <= 1'b0;
    end else begin
      r_pout   <= w_next;
      r_loaded <= r_loaded | w_any;
      r_chg    <= w_next != r_pout;
    end
  end
`ifdef PIPO_PARITY_EN
  logic r_par;
  // Injected error only corrupts the stored parity on an edge that actually loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_par <= ^RESET_VALUE;
    else      r_par <= (^w_next) ^ (w_any & par_err_inj);
  end
  assign par = r_par;
`endif
  assign pout   = r_pout;
  assign loaded = r_loaded;
  assign chg    = r_chg;
endmodule

// File: tb/tb_pipo_reg.sv
// tb_pipo_reg: table-driven check of pipo_reg (4-bit single lane and 8-bit two-lane instances).
module tb_pipo_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst4, ld4, en4, ld8;
  logic [3:0] pin4, pout4;
  logic       loaded4, chg4;
  logic       rst8, loaded8, chg8;
  logic [1:0] en8;
  logic [7:0] pin8, pout8;
`ifdef PIPO_PARITY_EN
  logic par_err_inj, par4, par8;
`endif
  int total = 0;
  int bad = 0;
  pipo_reg #(.WIDTH(4), .RESET_VALUE(4'b0000), .LANES(1)) u4 (
    .clk(clk), .rst(rst4), .ld(ld4), .lane_en(en4), .pin(pin4),
`ifdef PIPO_PARITY_EN
    .par_err_inj(par_err_inj), .par(par4),
`endif
    .pout(pout4), .loaded(loaded4), .chg(chg4));
  pipo_reg #(.WIDTH(8), .RESET_VALUE(8'h00), .LANES(2)) u8 (
    .clk(clk), .rst(rst8), .ld(ld8), .lane_en(en8), .pin(pin8),
`ifdef PIPO_PARITY_EN
    .par_err_inj(1'b0), .par(par8),
`endif
    .pout(pout8), .loaded(loaded8), .chg(chg8));
  typedef struct {
    bit         sel;
    logic       ld;
    logic [1:0] en;
    logic [7:0] pin;
    logic [7:0] pout;
    logic       loaded;
    logic       chg;
  } vec_t;
  vec_t q[$];
  vec_t tbl[$];
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic apply(input vec_t v, input string n);
    vec_t e;
    @(negedge clk);
    if (v.sel) begin ld8 = v.ld; en8 = v.en; pin8 = v.pin; end
    else begin ld4 = v.ld; en4 = v.en[0]; pin4 = v.pin[3:0]; end
    q.push_back(v);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({n, ".pout"},   e.sel ? pout8 : {4'h0, pout4},                e.pout);
    chk({n, ".loaded"}, {7'h0, e.sel ? loaded8 : loaded4},            {7'h0, e.loaded});
    chk({n, ".chg"},    {7'h0, e.sel ? chg8 : chg4},                  {7'h0, e.chg});
  endtask
  initial begin
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b1; pin4 = 4'b1101;
    rst8 = 1'b0; ld8 = 1'b0; en8 = 2'b00; pin8 = 8'h00;
`ifdef PIPO_PARITY_EN
    par_err_inj = 1'b0;
`endif
    #3;
    chk("rst.pout", {4'h0, pout4}, 8'h00);
    chk("rst.loaded", {7'h0, loaded4}, 8'h00);
    chk("rst.chg", {7'h0, chg4}, 8'h00);
    @(negedge clk);
    rst4 = 1'b1; rst8 = 1'b1;
    tbl.push_back('{0, 1, 2'b01, 8'h0A, 8'h0A, 1, 1});
    tbl.push_back('{0, 1, 2'b01, 8'h05, 8'h05, 1, 1});
    tbl.push_back('{0, 1, 2'b01, 8'h0B, 8'h0B, 1, 1});
    tbl.push_back('{0, 0, 2'b01, 8'h0D, 8'h0B, 1, 0});
    tbl.push_back('{0, 0, 2'b01, 8'h00, 8'h0B, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 8'h0B, 8'h0B, 1, 0});
    tbl.push_back('{0, 1, 2'b00, 8'h04, 8'h0B, 1, 0});
    tbl.push_back('{1, 1, 2'b00, 8'hA5, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 2'b10, 8'hA5, 8'hA0, 1, 1});
    tbl.push_back('{1, 1, 2'b10, 8'hA5, 8'hA0, 1, 0});
    tbl.push_back('{1, 1, 2'b01, 8'h3C, 8'hAC, 1, 1});
    tbl.push_back('{1, 0, 2'b11, 8'hFF, 8'hAC, 1, 0});
    tbl.push_back('{1, 1, 2'b11, 8'hAC, 8'hAC, 1, 0});
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // Asynchronous reset between edges, held across an edge with a pending load.
    @(negedge clk);
    ld4 = 1'b1; pin4 = 4'b0110;
    #2 rst4 = 1'b0;
    #1;
    chk("arst.pout", {4'h0, pout4}, 8'h00);
    chk("arst.loaded", {7'h0, loaded4}, 8'h00);
    @(posedge clk);
    #1;
    chk("arst_hold.pout", {4'h0, pout4}, 8'h00);
    chk("arst_hold.chg", {7'h0, chg4}, 8'h00);
    @(negedge clk);
    rst4 = 1'b1;
    apply('{0, 1, 2'b00, 8'h0F, 8'h00, 0, 0}, "nolane");
    apply('{0, 1, 2'b01, 8'h0D, 8'h0D, 1, 1}, "reload");
    apply('{0, 0, 2'b01, 8'h0D, 8'h0D, 1, 0}, "settle");
`ifdef PIPO_PARITY_EN
    apply('{0, 1, 2'b01, 8'h0B, 8'h0B, 1, 1}, "par1");
    chk("par.1011", {7'h0, par4}, 8'h01);
    apply('{0, 1, 2'b01, 8'h09, 8'h09, 1, 1}, "par0");
    chk("par.1001", {7'h0, par4}, 8'h00);
    par_err_inj = 1'b1;
    apply('{0, 1, 2'b01, 8'h09, 8'h09, 1, 0}, "parinj");
    chk("par.inj", {7'h0, par4}, 8'h01);
    par_err_inj = 1'b0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
